// File: rtl/harmonic_synth_engine_if.sv
// Bus between the additive-synthesis engine and its host: frame control,
// note/coefficient inputs, the external sine ROM port and the sample output.
interface harmonic_synth_engine_if #(
  parameter int NUM_NOTES     = 8,
  parameter int NUM_HARMONICS = 5,
  parameter int PHASE_W       = 32,
  parameter int SINE_ADDR_W   = 6,
  parameter int SAMPLE_W      = 8,
  parameter int MAG_W         = 9,
  parameter int OUT_W         = 8
);
  logic                                         step_in;
  logic [NUM_NOTES-1:0]                         notes_playing;
  logic [NUM_NOTES-1:0][PHASE_W-1:0]            base_increments;
  logic [NUM_HARMONICS-1:0][PHASE_W-1:0]        coeff_phases;
  logic [NUM_HARMONICS-1:0][MAG_W-1:0]          coeff_magnitudes;
  logic [4:0]                                   shift_in;
  logic [SINE_ADDR_W-1:0]                       sine_addr_out;
  logic signed [SAMPLE_W-1:0]                   sine_data_in;
  logic                                         busy_out;
  logic                                         sum_valid_out;
  logic signed [OUT_W-1:0]                      sum_out;
  logic                                         clip_out;
  logic                                         overrun_out;

  modport master (
    output step_in, notes_playing, base_increments, coeff_phases,
           coeff_magnitudes, shift_in, sine_data_in,
    input  sine_addr_out, busy_out, sum_valid_out, sum_out, clip_out, overrun_out
  );

  modport slave (
    input  step_in, notes_playing, base_increments, coeff_phases,
           coeff_magnitudes, shift_in, sine_data_in,
    output sine_addr_out, busy_out, sum_valid_out, sum_out, clip_out, overrun_out
  );
endinterface

// File: rtl/harmonic_synth_engine.sv
// Additive-synthesis engine: per frame, walks every note x harmonic voice,
// looks up its sine sample, weights it and sums into one saturated sample.
module harmonic_synth_engine #(
  parameter int NUM_NOTES     = 8,
  parameter int NUM_HARMONICS = 5,
  parameter int PHASE_W       = 32,
  parameter int SINE_ADDR_W   = 6,
  parameter int SAMPLE_W      = 8,
  parameter int MAG_W         = 9,
  parameter int OUT_W         = 8
) (
  input logic               clk_in,
  input logic               rst_in,
  harmonic_synth_engine_if.slave bus
);
  localparam int N      = NUM_NOTES * NUM_HARMONICS;
  localparam int V_W    = (N > 1) ? $clog2(N) : 1;
  localparam int NI_W   = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
  localparam int H_W    = (NUM_HARMONICS > 1) ? $clog2(NUM_HARMONICS) : 1;
  localparam int PROD_W = MAG_W + SAMPLE_W + 1;
  localparam int ACC_W  = PROD_W + $clog2(N);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;

  state_t                            state;
  logic [V_W-1:0]                    v_idx;
  logic [NI_W-1:0]                   n_idx;
  logic [H_W-1:0]                    h_idx;
  logic [1:0]                        drain_cnt;
  logic [NUM_NOTES-1:0]              snap_notes;
  logic [NUM_NOTES-1:0]              prev_notes;
  logic [PHASE_W-1:0]                phase [N];
  logic [NUM_HARMONICS-1:0][MAG_W-1:0] mag_snap;
  logic [4:0]                        shift_snap;

  logic                              vld_p0, vld_p1, vld_p2;
  logic                              on_p0;
  logic [H_W-1:0]                    h_p0, h_p1;
  logic signed [SAMPLE_W-1:0]        sample_p1;
  logic signed [PROD_W-1:0]          prod_p2;
  logic signed [ACC_W-1:0]           acc;
  logic signed [ACC_W-1:0]           acc_shifted;

  logic                              note_on, rising;
  logic [PHASE_W-1:0]                phase_used, phase_inc, phase_next;
  logic                              frame_start;

  function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] val);
    logic signed [ACC_W-1:0] hi, lo;
    hi = ACC_W'((1 << (OUT_W - 1)) - 1);
    lo = ~hi;
    if (val > hi)      return {1'b1, hi[OUT_W-1:0]};
    else if (val < lo) return {1'b1, lo[OUT_W-1:0]};
    else               return {1'b0, val[OUT_W-1:0]};
  endfunction

  // A rising note restarts from the harmonic's start phase; an off note parks there.
  always_comb begin
    note_on     = snap_notes[n_idx];
    rising      = note_on & ~prev_notes[n_idx];
    phase_used  = rising ? bus.coeff_phases[h_idx] : phase[v_idx];
    phase_inc   = bus.base_increments[n_idx] * (PHASE_W'(h_idx) + PHASE_W'(1));
    phase_next  = note_on ? (phase_used + phase_inc) : bus.coeff_phases[h_idx];
    frame_start = (state == IDLE) && bus.step_in;
    acc_shifted = acc >>> shift_snap;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state             <= IDLE;
      v_idx             <= '0;
      n_idx             <= '0;
      h_idx             <= '0;
      drain_cnt         <= '0;
      snap_notes        <= '0;
      prev_notes        <= '0;
      vld_p0            <= 1'b0;
      vld_p1            <= 1'b0;
      vld_p2            <= 1'b0;
      bus.sine_addr_out <= '0;
      bus.busy_out      <= 1'b0;
      bus.sum_valid_out <= 1'b0;
      bus.sum_out       <= '0;
      bus.clip_out      <= 1'b0;
      bus.overrun_out   <= 1'b0;
      for (int i = 0; i < N; i++) phase[i] <= '0;
    end else begin
      bus.sum_valid_out <= 1'b0;
      bus.overrun_out   <= bus.step_in && (state != IDLE);
      vld_p0            <= 1'b0;
      vld_p1            <= vld_p0;
      vld_p2            <= vld_p1;
      case (state)
        IDLE: begin
          if (bus.step_in) begin
            snap_notes   <= bus.notes_playing;
            bus.busy_out <= 1'b1;
            v_idx        <= '0;
            n_idx        <= '0;
            h_idx        <= '0;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          bus.sine_addr_out <= phase_used[PHASE_W-1 -: SINE_ADDR_W];
          phase[v_idx]      <= phase_next;
          vld_p0            <= 1'b1;
          v_idx             <= v_idx + 1'b1;
          if (h_idx == H_W'(NUM_HARMONICS - 1)) begin
            h_idx <= '0;
            n_idx <= n_idx + 1'b1;
          end else begin
            h_idx <= h_idx + 1'b1;
          end
          if (v_idx == V_W'(N - 1)) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == 2'd2) state <= OUTPUT;
        end
        OUTPUT: begin
          {bus.clip_out, bus.sum_out} <= saturate(acc_shifted);
          bus.sum_valid_out <= 1'b1;
          bus.busy_out      <= 1'b0;
          prev_notes        <= snap_notes;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (frame_start) begin
      mag_snap   <= bus.coeff_magnitudes;
      shift_snap <= bus.shift_in;
    end
    // p0: address issued, ROM answers during the following cycle
    on_p0     <= note_on;
    h_p0      <= h_idx;
    // p1: sample captured, silenced for off notes
    sample_p1 <= on_p0 ? bus.sine_data_in : '0;
    h_p1      <= h_p0;
    // p2: magnitude weighting
    prod_p2   <= $signed({1'b0, mag_snap[h_p1]}) * sample_p1;
    // p3: accumulation, wide enough for N full-scale products
    if (frame_start)  acc <= '0;
    else if (vld_p2)  acc <= acc + ACC_W'(prod_p2);
  end
endmodule

// File: tb/tb_harmonic_synth_engine.sv
// Randomised self-checking bench for harmonic_synth_engine against a
// frame-level additive-synthesis model.
module tb_harmonic_synth_engine;
  localparam int NN = 8;
  localparam int NH = 5;
  localparam int NV = NN * NH;
  localparam int LAT = NV + 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  harmonic_synth_engine_if bus ();

  harmonic_synth_engine dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic signed [7:0] rom [64];
  assign bus.sine_data_in = rom[bus.sine_addr_out];

  int checks   = 0;
  int failures = 0;

  logic [31:0] mph [NV];
  logic [7:0]  mprev;
  logic [5:0]  exp_addr [NV];
  logic        exp_on [NV];
  logic [5:0]  cap_addr [NV];
  longint      exp_sum;
  longint      exp_clip;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic rom_const(input int val);
    for (int i = 0; i < 64; i++) rom[i] = 8'(val);
  endtask

  task automatic rom_random();
    for (int i = 0; i < 64; i++) rom[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) mph[v] = '0;
    mprev = '0;
  endtask

  // One frame of additive synthesis straight from the rules.
  task automatic model_frame();
    logic [7:0]  snap;
    logic [31:0] used;
    longint      acc, r;
    snap = bus.notes_playing;
    acc  = 0;
    for (int n = 0; n < NN; n++) begin
      for (int h = 0; h < NH; h++) begin
        int v;
        v = n * NH + h;
        exp_on[v] = snap[n];
        if (snap[n]) begin
          used        = mprev[n] ? mph[v] : bus.coeff_phases[h];
          mph[v]      = used + bus.base_increments[n] * 32'(h + 1);
          exp_addr[v] = used[31:26];
          acc += longint'(bus.coeff_magnitudes[h]) * longint'(rom[used[31:26]]);
        end else begin
          mph[v]      = bus.coeff_phases[h];
          exp_addr[v] = '0;
        end
      end
    end
    r = acc >>> bus.shift_in;
    if (r > 127)       begin exp_sum = 127;  exp_clip = 1; end
    else if (r < -128) begin exp_sum = -128; exp_clip = 1; end
    else               begin exp_sum = r;    exp_clip = 0; end
    mprev = snap;
  endtask

  task automatic run_frame(input int ovr_k, input int toggle_k,
                           input logic [7:0] toggle_val, input bit chk_addr);
    int k, busy_cnt, ovr_cnt, valid_k;
    model_frame();
    @(negedge clk);
    bus.step_in = 1'b1;
    @(posedge clk);
    #1 bus.step_in = 1'b0;
    k = 0; busy_cnt = 0; ovr_cnt = 0; valid_k = 200;
    while (k < 200) begin
      if (bus.busy_out) busy_cnt++;
      if (bus.overrun_out) ovr_cnt++;
      if (k >= 1 && k <= NV) cap_addr[k-1] = bus.sine_addr_out;
      if (bus.sum_valid_out) begin valid_k = k; break; end
      if (k == ovr_k) bus.step_in = 1'b1;
      if (k == ovr_k + 1) bus.step_in = 1'b0;
      if (k == toggle_k) bus.notes_playing = toggle_val;
      @(posedge clk);
      #1;
      k++;
    end
    bus.step_in = 1'b0;
    check_val("latency", valid_k, LAT);
    check_val("busy_cycles", busy_cnt, LAT);
    check_val("sum_out", bus.sum_out, exp_sum);
    check_val("clip_out", bus.clip_out, exp_clip);
    check_val("overrun_pulses", ovr_cnt, (ovr_k >= 0) ? 1 : 0);
    if (chk_addr)
      for (int v = 0; v < NV; v++)
        if (exp_on[v]) check_val($sformatf("addr_v%0d", v), cap_addr[v], exp_addr[v]);
    @(posedge clk);
    #1;
    check_val("valid_single_pulse", bus.sum_valid_out, 0);
    check_val("sum_held", bus.sum_out, exp_sum);
  endtask

  task automatic randomize_inputs();
    bus.notes_playing = 8'($urandom_range(0, 255));
    for (int n = 0; n < NN; n++) bus.base_increments[n] = $urandom;
    for (int h = 0; h < NH; h++) begin
      bus.coeff_phases[h]     = $urandom;
      bus.coeff_magnitudes[h] = 9'($urandom_range(0, 511));
    end
    bus.shift_in = 5'($urandom_range(0, 12));
    rom_random();
  endtask

  initial begin
    int vcnt;
    bus.step_in       = 1'b0;
    bus.notes_playing = '0;
    bus.shift_in      = '0;
    for (int n = 0; n < NN; n++) bus.base_increments[n] = '0;
    for (int h = 0; h < NH; h++) begin
      bus.coeff_phases[h]     = '0;
      bus.coeff_magnitudes[h] = '0;
    end
    rom_const(0);
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_sum_out", bus.sum_out, 0);
    check_val("rst_busy", bus.busy_out, 0);
    check_val("rst_valid", bus.sum_valid_out, 0);
    check_val("rst_clip", bus.clip_out, 0);
    check_val("rst_overrun", bus.overrun_out, 0);
    check_val("rst_addr", bus.sine_addr_out, 0);
    @(negedge clk);
    rst = 1'b0;

    // All notes off
    for (int h = 0; h < NH; h++) bus.coeff_magnitudes[h] = 9'd511;
    rom_const(127);
    run_frame(-1, -1, 8'h00, 1'b0);
    check_val("off_sum_zero", bus.sum_out, 0);

    // Single fundamental, scaled
    bus.notes_playing = 8'h01;
    for (int h = 0; h < NH; h++) bus.coeff_magnitudes[h] = (h == 0) ? 9'd256 : 9'd0;
    rom_const(100);
    bus.shift_in = 5'd8;
    run_frame(-1, -1, 8'h00, 1'b0);
    check_val("note0_sum_100", bus.sum_out, 100);

    // Full-scale saturation both ways
    bus.notes_playing = 8'hFF;
    for (int h = 0; h < NH; h++) bus.coeff_magnitudes[h] = 9'd511;
    bus.shift_in = 5'd0;
    rom_const(127);
    run_frame(-1, -1, 8'h00, 1'b0);
    check_val("sat_pos", bus.sum_out, 127);
    rom_const(-128);
    run_frame(-1, -1, 8'h00, 1'b0);
    check_val("sat_neg", bus.sum_out, -128);

    // Phase progression and retrigger on note 0
    bus.notes_playing = 8'h00;
    bus.base_increments[0] = 32'h1000_0000;
    for (int h = 0; h < NH; h++) bus.coeff_phases[h] = '0;
    rom_random();
    run_frame(-1, -1, 8'h00, 1'b0);
    bus.notes_playing = 8'h01;
    for (int f = 0; f < 3; f++) begin
      run_frame(-1, -1, 8'h00, 1'b1);
      check_val($sformatf("h0_addr_f%0d", f), cap_addr[0], 4 * f);
      check_val($sformatf("h1_addr_f%0d", f), cap_addr[1], 8 * f);
    end
    bus.notes_playing = 8'h00;
    run_frame(-1, -1, 8'h00, 1'b0);
    bus.notes_playing = 8'h01;
    run_frame(-1, -1, 8'h00, 1'b1);
    check_val("retrig_h0", cap_addr[0], 0);
    check_val("retrig_h1", cap_addr[1], 0);

    // Overrun, then randomised frames (one with a mid-frame note toggle)
    randomize_inputs();
    run_frame(10, -1, 8'h00, 1'b1);
    for (int f = 0; f < 6; f++) begin
      randomize_inputs();
      if (f == 3) run_frame(-1, 15, ~bus.notes_playing, 1'b1);
      else        run_frame(-1, -1, 8'h00, 1'b1);
    end
    randomize_inputs();
    run_frame(LAT - 1, -1, 8'h00, 1'b0);

    // Asynchronous reset mid-frame
    randomize_inputs();
    bus.notes_playing = 8'hFF;
    bus.shift_in = 5'd0;
    @(negedge clk);
    bus.step_in = 1'b1;
    @(posedge clk);
    #1 bus.step_in = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_val("arst_sum_out", bus.sum_out, 0);
    check_val("arst_busy", bus.busy_out, 0);
    check_val("arst_clip", bus.clip_out, 0);
    check_val("arst_addr", bus.sine_addr_out, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (bus.sum_valid_out) vcnt++;
    end
    check_val("arst_no_valid", vcnt, 0);
    run_frame(-1, -1, 8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/harmonic_synth_engine.md
Name: harmonic_synth_engine

Overview:
- Parametrised additive-synthesis engine. One audio frame per `step_in` pulse.
- Voices are enumerated as NUM_NOTES × NUM_HARMONICS. Each voice has a phase accumulator, a sine lookup through an external 1-cycle sine ROM port, magnitude weighting, and signed accumulation.
- Produces one saturated, programmably scaled sample per frame for the DAC/PWM path.
- Generalises the fixed 8×5 summer:
  - harmonic increments are derived as (h+1)·base per note rather than a full table;
  - phase retriggers on note-on;
  - output is saturated, with clip and overrun flags.

Parameters:
- NUM_NOTES, 8, number of note channels.
- NUM_HARMONICS, 5, harmonics per note (h = 0 is the fundamental).
- PHASE_W, 32, phase accumulator width.
- SINE_ADDR_W, 6, sine ROM address width; equals phase[PHASE_W-1 -: SINE_ADDR_W].
- SAMPLE_W, 8, signed sine sample width.
- MAG_W, 9, unsigned harmonic magnitude width.
- OUT_W, 8, signed output sample width.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous and active-high.
- step_in  input  1  frame strobe (8 kHz), 1-cycle pulse.
- notes_playing  input  NUM_NOTES  level, bit n = note n on.
- base_increments  input  NUM_NOTES×PHASE_W  fundamental phase increment per note.
- coeff_phases  input  NUM_HARMONICS×PHASE_W  start phase per harmonic.
- coeff_magnitudes  input  NUM_HARMONICS×MAG_W  unsigned weight per harmonic.
- shift_in  input  5  arithmetic right shift applied to the accumulator before saturation.
- sine_addr_out  output  SINE_ADDR_W  ROM address, registered.
- sine_data_in  input  SAMPLE_W  signed ROM data, valid exactly 1 cycle after its address.
- busy_out  output  1  high while a frame is in progress.
- sum_valid_out  output  1  1-cycle pulse, sum_out updated.
- sum_out  output  OUT_W  signed frame sample, held until the next frame.
- clip_out  output  1  registered with sum_out; 1 = saturation occurred in that frame.
- overrun_out  output  1  1-cycle pulse when step_in arrives while busy.

Behaviour:
- N = NUM_NOTES·NUM_HARMONICS. Voice index v = n·NUM_HARMONICS + h, issued in ascending v order.
- Reset (asynchronous, any time including mid-frame):
  - state returns to IDLE;
  - all phases and the prev-note register are cleared to 0;
  - all outputs are 0.
- State IDLE:
  - busy_out = 0.
  - When step_in = 1, latch coeff_magnitudes, shift_in and notes_playing (snapshot), clear the accumulator, then go to ISSUE.
  - The other inputs must be held stable until sum_valid_out.
- State ISSUE (N cycles): each cycle, for voice v:
  - sine_addr_out <= top SINE_ADDR_W bits of the voice's phase **before** update.
  - If the note is on and its prev bit is 0 (rising edge): phase used = coeff_phases[h], stored = coeff_phases[h] + (h+1)·base_increments[n].
  - If the note is on and prev = 1: phase used = current phase, stored = phase + (h+1)·base_increments[n].
  - If the note is off: stored = coeff_phases[h]; the voice contributes 0.
  - All phase arithmetic is modulo 2^PHASE_W.
  - (h+1)·base is computed at PHASE_W bits, truncated.
- Datapath pipeline:
  - cycle +1: sample sine_data_in, forcing it to 0 if the voice's note is off;
  - cycle +2: product = $signed({1'b0, mag[h]}) × sample, width MAG_W+SAMPLE_W+1;
  - cycle +3: accumulate into ACC_W = MAG_W+SAMPLE_W+1+$clog2(N) signed bits, which cannot overflow.
- State DRAIN (3 cycles): the pipeline empties.
- State OUTPUT (1 cycle):
  - r = acc >>> shift_in;
  - sum_out = r clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1];
  - clip_out = 1 if clamped;
  - sum_valid_out = 1;
  - prev-note register <= snapshot;
  - return to IDLE.
- Latency: if step_in is sampled at edge T, sum_valid_out is high in the cycle after edge T+N+4 (44 cycles at defaults). busy_out is high from T+1 through the OUTPUT cycle inclusive.
- step_in while busy_out = 1: the step is ignored, overrun_out pulses for 1 cycle, and the running frame is unaffected.
- step_in in the OUTPUT cycle counts as busy, so it is an overrun.
- A note toggled mid-frame has no effect until the next frame, because the snapshot is used.
- When all notes are off, the frame still runs and produces 0.

Test Plan:
- All notes off, magnitudes 511, ROM model returns 127 -> sum_out = 0, clip_out = 0, sum_valid_out pulse exactly 44 cycles after step_in, busy_out high for 44 cycles.
- Note 0 on, mag = {256, 0, 0, 0, 0}, ROM constant 100, shift_in = 8 -> acc = 25600, sum_out = 100 (0x64), clip_out = 0.
- All notes on, all mag = 511, ROM constant 127, shift_in = 0 -> acc = 40·64897 = 2,595,880, sum_out = 127, clip_out = 1; ROM constant -128 -> sum_out = -128, clip_out = 1.
- Note 0 on, base_increments[0] = 0x1000_0000, coeff_phases all 0; observe sine_addr_out over three frames:
  - h0: 0x00, 0x04, 0x08;
  - h1: 0x00, 0x08, 0x10;
  - turn note off for one frame and back on -> addresses restart at 0x00.
- step_in pulsed 10 cycles after a frame starts -> overrun_out 1-cycle pulse, sum_valid_out still at 44, exactly one valid pulse.
- rst_in asserted 20 cycles into a frame -> outputs 0 immediately (asynchronously), no sum_valid_out; next step_in retriggers all active notes from coeff_phases.
